// File: rtl/serializer_buf.sv
// Parallel-to-serial converter with a one-word holding register; MSB- or LSB-first per word.
// Latency: first bit valid one cycle after accept; back-to-back words leave no bubble.
// Backpressure: ser_ready_i low freezes the outputs; busy_o high means new words are ignored.
module serializer_buf #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   input  logic              lsb_first_i,
   input  logic              ser_ready_i,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              ser_last_o,
   output logic              busy_o
);

   typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

   // Counter is one bit wider than the mod field so a full DATA_W word fits.
   localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
   localparam logic [MOD_W:0] MIN_LEN  = (MOD_W+1)'(3);
   localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [MOD_W:0]    r_cnt;
   logic              r_lsb;
   logic [DATA_W-1:0] r_hold_dat;
   logic [MOD_W:0]    r_hold_len;
   logic              r_hold_lsb;
   logic              r_hold_full;

   logic [MOD_W:0]    w_len;
   logic              w_len_ok;
   logic              w_acc;
   logic              w_xfer;
   logic              w_last_xfer;
   logic              w_ld_hold;
   logic              w_ld_in;
   logic              w_to_hold;

   // Decode word length, acceptance and the load source for the shifter.
   always_comb begin
      w_len       = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
      w_len_ok    = (w_len >= MIN_LEN);
      w_acc       = data_val_i & ~r_hold_full & w_len_ok;
      w_xfer      = (r_state == ST_SHIFT) & ser_ready_i;
      w_last_xfer = w_xfer & (r_cnt == ONE);
      // A full holding register always wins the reload slot; busy_o blocks a
      // simultaneous accept in that case, so the two loads never collide.
      w_ld_hold   = w_last_xfer & r_hold_full;
      w_ld_in     = w_acc & ((r_state == ST_IDLE) | w_last_xfer);
      w_to_hold   = w_acc & ~((r_state == ST_IDLE) | w_last_xfer);
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (srst_i) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state and output decode; outputs are pure functions of the shifter state.
   always_comb begin
      w_state_nxt    = r_state;
      ser_data_val_o = 1'b0;
      ser_data_o     = 1'b0;
      ser_last_o     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_acc) w_state_nxt = ST_SHIFT;
         end
         ST_SHIFT: begin
            ser_data_val_o = 1'b1;
            ser_data_o     = r_lsb ? r_shift[0] : r_shift[DATA_W-1];
            ser_last_o     = (r_cnt == ONE);
            if (w_last_xfer && !r_hold_full && !w_acc) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shifter and remaining-bit counter: reload or shift one bit per transfer.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_shift <= '0;
         r_cnt   <= '0;
         r_lsb   <= 1'b0;
      end else if (w_ld_hold) begin
         r_shift <= r_hold_dat;
         r_cnt   <= r_hold_len;
         r_lsb   <= r_hold_lsb;
      end else if (w_ld_in) begin
         r_shift <= data_i;
         r_cnt   <= w_len;
         r_lsb   <= lsb_first_i;
      end else if (w_xfer) begin
         r_shift <= r_lsb ? (r_shift >> 1) : (r_shift << 1);
         r_cnt   <= r_cnt - ONE;
      end
   end

   // Holding register: filled when the shifter is busy, drained on the last bit.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         r_hold_full <= 1'b0;
         r_hold_dat  <= '0;
         r_hold_len  <= '0;
         r_hold_lsb  <= 1'b0;
      end else if (w_to_hold) begin
         r_hold_full <= 1'b1;
         r_hold_dat  <= data_i;
         r_hold_len  <= w_len;
         r_hold_lsb  <= lsb_first_i;
      end else if (w_ld_hold) begin
         r_hold_full <= 1'b0;
      end
   end

   assign busy_o = r_hold_full;

endmodule
